// File: rtl/cmp_rr_bank_if.sv
// cmp_rr_bank_if: issue-side and CDB-side signal bundle for cmp_rr_bank.
//   in_valid/in_ready  per-lane issue handshake
//   in_r1/in_r2        per-lane operands
//   in_op              per-lane funct3
//   in_tag             per-lane ROB tag
//   in_is_br           per-lane branch (1) / set-compare (0)
//   in_pred_taken      per-lane predicted direction
//   cdb_valid/ready    single CDB port handshake
//   cdb_tag/data       broadcast result
//   cdb_mispredict     branch mispredict flag
//   pending            count of full lane buffers
// slave = the compare bank, master = issue logic / CDB consumer.
interface cmp_rr_bank_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [LANES-1:0]             in_valid;
    logic [LANES-1:0]             in_ready;
    logic [LANES-1:0][XLEN-1:0]   in_r1;
    logic [LANES-1:0][XLEN-1:0]   in_r2;
    logic [LANES-1:0][2:0]        in_op;
    logic [LANES-1:0][TAG_W-1:0]  in_tag;
    logic [LANES-1:0]             in_is_br;
    logic [LANES-1:0]             in_pred_taken;
    logic                         cdb_valid;
    logic                         cdb_ready;
    logic [TAG_W-1:0]             cdb_tag;
    logic [XLEN-1:0]              cdb_data;
    logic                         cdb_mispredict;
    logic [CNT_W-1:0]             pending;

    modport master (
        output in_valid, in_r1, in_r2, in_op, in_tag, in_is_br, in_pred_taken, cdb_ready,
        input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, pending
    );

    modport slave (
        input  in_valid, in_r1, in_r2, in_op, in_tag, in_is_br, in_pred_taken, cdb_ready,
        output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_mispredict, pending
    );
endinterface

// File: rtl/cmp_rr_bank.sv
// cmp_rr_bank: per-lane RV32I branch-compare with one result buffer per lane,
// drained onto a single CDB port by a round-robin arbiter.
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  drop all buffered results and this cycle's issues
//   bus    cmp_rr_bank_if.slave (issue handshake, CDB handshake, pending)
module cmp_rr_bank #(
    parameter int unsigned LANES = 8,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    cmp_rr_bank_if.slave       bus
);
    localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             res;
        logic             mis;
    } entry_t;

    entry_t            buf_q [LANES];
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0]  pending_q;
    logic              lock_q;
    logic [PTR_W-1:0]  lock_idx_q;

    logic [LANES-1:0]  buf_valid;
    logic [LANES-1:0]  cmp_res;
    logic [LANES-1:0]  cmp_mis;
    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;
    logic [LANES-1:0]  grant_oh;
    logic [LANES-1:0]  drain;
    logic [LANES-1:0]  ready;
    logic [LANES-1:0]  accept;
    logic              xfer;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  pending_nxt;

    // Returns {result, mispredict}; undefined funct3 yields 0/0.
    function automatic logic [1:0] eval_cmp(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      op,
        input logic            is_br,
        input logic            pred
    );
        logic res;
        logic known;
        res   = 1'b0;
        known = 1'b1;
        case (op)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) < $signed(b));
            3'b101:  res = !($signed(a) < $signed(b));
            3'b110:  res = (a < b);
            3'b111:  res = !(a < b);
            default: known = 1'b0;
        endcase
        return {res, is_br & known & (res != pred)};
    endfunction

    // Combinational compare on the issue inputs.
    always_comb begin
        cmp_res = '0;
        cmp_mis = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            {cmp_res[i], cmp_mis[i]} = eval_cmp(bus.in_r1[i], bus.in_r2[i], bus.in_op[i],
                                                bus.in_is_br[i], bus.in_pred_taken[i]);
        end
    end

    always_comb begin
        buf_valid = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            buf_valid[i] = buf_q[i].valid;
        end
    end

    // Round-robin pick from rr_ptr. A stalled presentation stays locked so a
    // lane filling in ahead of it cannot steal the port before the transfer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (lock_q) begin
            grant_found = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int k = 0; k < int'(LANES); k++) begin
                cand = PTR_W'((32'(rr_ptr_q) + 32'(k)) % 32'(LANES));
                if (!grant_found && buf_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Handshake terms and pending bookkeeping.
    always_comb begin
        grant_oh = grant_found ? (LANES'(1) << grant_idx) : '0;
        xfer     = grant_found & bus.cdb_ready;
        drain    = grant_oh & {LANES{bus.cdb_ready}};
        ready    = ~buf_valid | drain;
        accept   = bus.in_valid & ready & ~{LANES{flush}};
        acc_cnt  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            acc_cnt = acc_cnt + CNT_W'(accept[i]);
        end
        pending_nxt = pending_q + acc_cnt - CNT_W'(xfer);
    end

    assign bus.in_ready       = ready;
    assign bus.cdb_valid      = grant_found;
    assign bus.cdb_tag        = grant_found ? buf_q[grant_idx].tag : '0;
    assign bus.cdb_data       = grant_found ? XLEN'(buf_q[grant_idx].res) : '0;
    assign bus.cdb_mispredict = grant_found & buf_q[grant_idx].mis;
    assign bus.pending        = pending_q;

    // Lane buffers: flush beats accept beats drain; accept covers drain+refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LANES); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (flush) begin
                    buf_q[i].valid <= 1'b0;
                end else if (accept[i]) begin
                    buf_q[i] <= '{valid: 1'b1, tag: bus.in_tag[i],
                                  res: cmp_res[i], mis: cmp_mis[i]};
                end else if (drain[i]) begin
                    buf_q[i].valid <= 1'b0;
                end
            end
        end
    end

    // Arbiter pointer, grant lock and pending counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (flush) begin
                rr_ptr_q <= '0;
            end else if (xfer) begin
                rr_ptr_q <= (grant_idx == PTR_W'(LANES - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
            pending_q  <= flush ? '0 : pending_nxt;
            lock_q     <= grant_found & ~bus.cdb_ready & ~flush;
            lock_idx_q <= grant_idx;
        end
    end
endmodule

// File: doc/cmp_rr_bank.md
# cmp_rr_bank

Parametrised branch-compare bank for the out-of-order core. It evaluates RV32I branch conditions for up to LANES reservation-station issue slots per cycle and holds one registered result per lane. It flags mispredictions against the front end's predicted direction. Buffered results are serialised onto a single CDB port through a round-robin arbiter with valid/ready backpressure.

## Interface
- LANES, default 8: number of issue lanes / result buffers (≥2).
- XLEN, default 32: operand and result width.
- TAG_W, default 4: ROB tag width.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  active-low asynchronous reset (asserted when 0).
- flush  input  1  kill all buffered results and same-cycle inputs.
- in_valid  input  LANES  per-lane issue request.
- in_ready  output  LANES  per-lane accept; transfer = in_valid[i] & in_ready[i].
- in_r1, in_r2  input  LANES×XLEN  operands.
- in_op  input  LANES×3  funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- in_tag  input  LANES×TAG_W  ROB tag.
- in_is_br  input  LANES  1 = branch (mispredict evaluated), 0 = set-compare (data only).
- in_pred_taken  input  LANES  predicted direction.
- cdb_valid  output  1  result present on CDB port.
- cdb_ready  input  1  global CDB grant; transfer = cdb_valid & cdb_ready.
- cdb_tag  output  TAG_W  tag of presented result.
- cdb_data  output  XLEN  result: 1 if condition true, else 0 (zero-extended).
- cdb_mispredict  output  1  in_is_br & (result != in_pred_taken).
- pending  output  $clog2(LANES+1)  number of full lane buffers.

## Operation
- Per lane: one result buffer {valid, tag, data bit, mispredict}. Comparison is combinational on input; the buffer captures it on the transfer edge.
- Signed compares (blt, bge) use two's complement over XLEN. Unsigned compares (bltu, bgeu) use unsigned magnitude. bge = !blt; bgeu = !bltu.
- Opcodes 010/011: result 0 and mispredict 0; the result is still buffered and broadcast.
- in_ready[i] = !buf_valid[i] | (grant[i] & cdb_ready). in_ready is independent of in_valid and of flush.
- Arbiter: rr_ptr (index, reset 0). The grant goes to the first valid buffer at or after rr_ptr, wrapping modulo LANES. If no buffer is valid, there is no grant and cdb_valid = 0.
- CDB outputs are a combinational mux of the granted buffer. cdb_tag and cdb_data are 0 when cdb_valid = 0.
- On a CDB transfer from lane g: clear buf_valid[g] and set rr_ptr to (g+1) mod LANES. Without a transfer, rr_ptr holds. The selection must not change while cdb_valid is held and cdb_ready is low.
- The same lane may drain and refill in one cycle. The new entry then becomes visible next cycle.
- flush: all buf_valid clear at the next edge, inputs in the flush cycle are discarded, and rr_ptr resets to 0. A CDB transfer in the flush cycle still counts as completed for the consumer.
- pending: registered popcount of buf_valid, updated each edge by (+accepts − drain), or forced to 0 on flush.

## Timing
- Reset (rst = 0, async): buf_valid all 0, rr_ptr 0, and pending 0. The outputs are then cdb_valid 0, cdb_tag 0, cdb_data 0, cdb_mispredict 0, and in_ready all 1. Reset mid-operation drops all results immediately.
- Latency: input accepted at edge N gives cdb_valid in cycle N+1 at the earliest. This is one cycle of added latency over purely combinational compare.
- Throughput: one CDB result per cycle. Per-lane throughput is one result per cycle while that lane holds the grant and cdb_ready stays high.
- Backpressure: with cdb_ready = 0, buffered lanes hold their values and deassert in_ready. The presented result is stable until transferred or flushed.

## Test plan
- Reset then idle: rst low mid-traffic -> in the same cycle cdb_valid 0 and pending 0; after release, in_ready = all 1s.
- Compare table, lane 0, cdb_ready = 1: r1 = 0xFFFFFFFF, r2 = 1. Required results: blt -> data 1, bltu -> 0, bge -> 0, bgeu -> 1, beq -> 0, bne -> 1. Each result must appear the cycle after issue with the matching tag.
- Mispredict: beq with r1 = r2 = 5, pred_taken 0, is_br 1 -> cdb_mispredict 1. The same input with is_br 0 -> data 1, mispredict 0.
- Round-robin fairness: all 8 lanes issue in one cycle with tags 0..7, cdb_ready = 1 -> tags broadcast in order 0..7 over 8 consecutive cycles. pending counts 8, 7, …, 0, and in_ready[i] reasserts when lane i drains. Issue lanes 7 and 1 after rr_ptr = 6 -> lane 7 first, then lane 1.
- Backpressure: lane 3 is full and cdb_ready = 0 for 4 cycles -> cdb outputs stay stable, in_ready[3] = 0, and other lanes still accept. When cdb_ready rises, lane 3 drains first and the other lanes follow in round-robin order.
- Flush: 5 lanes are full and new issues arrive in the flush cycle -> next cycle pending 0, cdb_valid 0, and none of the flushed tags is ever broadcast.
